uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter that drives the SoC's TXD pin, which is currently tied low. It is the transmit-direction counterpart of RXD.
- Converts one byte per handshake into an 8N1 frame (start, 8 data bits LSB first, stop) at a fixed baud set by a clock-divider parameter.
- Sits beside the core and is fed by a future memory-mapped UART data register. The idle line is high.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per serial bit (27 MHz / 115200). Legal range 2..65535. Counter width is 16 bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tx_data  input  8  byte to send; sampled only on the accept edge
- tx_valid  input  1  producer has a byte on tx_data
- tx_ready  output  1  high only in IDLE; a byte is accepted on any posedge clk with tx_valid && tx_ready
- tx_busy  output  1  high from the accept edge until the return to IDLE; equals ~tx_ready
- txd  output  1  serial line, registered

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset, sampled at posedge clk. Reset has priority over every other event.
- Reset values: state=IDLE, txd=1, tx_ready=1, tx_busy=0, bit counter=0, baud counter=0, shift register=0.
- States are IDLE, START, DATA, STOP (plus PARITY, see Optional Feature). State, txd and counters are registered. tx_ready/tx_busy are decoded from the registered state.
- IDLE: txd=1.
  - On the accept edge: shift register <= tx_data, state <= START, txd <= 0, baud counter <= 0.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. Each line level is held for exactly CLKS_PER_BIT cycles.
- On a terminal count (CLKS_PER_BIT-1), the counter resets to 0 and the state advances:
  - START -> DATA: txd <= shift[0], bit counter <= 0.
  - DATA, bit counter < 7: shift right by 1, txd <= next bit, bit counter += 1.
  - DATA, bit counter == 7: state <= STOP, txd <= 1.
  - STOP: state <= IDLE; txd stays 1.
- Latency:
  - The start bit appears on txd the cycle after the accept edge.
  - tx_ready reasserts exactly 10*CLKS_PER_BIT cycles after the accept edge.
- Back-to-back: if tx_valid is held high, the next byte is accepted in the first IDLE cycle. The acceptance period is therefore 10*CLKS_PER_BIT+1 cycles, with one extra idle-high cycle between frames.
- tx_valid and tx_data while busy: ignored, not queued. A changing tx_data mid-frame has no effect on txd.
- Reset mid-frame: the frame is aborted. On the next edge txd=1, tx_ready=1, and all counters are cleared. No partial byte is resumed.
- txd must never glitch: it changes only at posedge clk and only at bit boundaries or on reset.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - txd = even parity (XOR of the accepted 8 data bits), held for CLKS_PER_BIT cycles.
  - Frame is 11 bits; tx_ready reasserts 11*CLKS_PER_BIT cycles after accept.
  - The parity value is computed from the shift-register copy captured at accept, not from the live tx_data.
- Undefined:
  - The PARITY state and its logic are absent. Frame is 8N1 (10 bits), exactly as above.

Test Plan:
- Reset: assert reset for 2 cycles with tx_valid=1 -> txd=1, tx_ready=1, tx_busy=0 throughout, and nothing is accepted.
- Single byte 0x55 with CLKS_PER_BIT=4 -> txd levels 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, starting 1 cycle after accept. tx_ready is low for exactly 40 cycles.
- Back-to-back 0xA5 then 0x3C with tx_valid held, CLKS_PER_BIT=4:
  - Second start bit begins 41 cycles after the first accept.
  - Decoded bytes are 0xA5 then 0x3C.
  - txd is high in the single gap cycle.
- Pulse tx_valid with tx_data=0xFF during data bit 2 of an in-flight 0x00 frame -> the pulse is ignored, the frame decodes 0x00, and no second frame follows.
- Reset asserted during data bit 3 of 0x81 -> txd=1 and tx_ready=1 on the next edge. A new 0x42 accepted afterwards is sent as a complete, correct frame.
- With UART_TX_PARITY_EN, CLKS_PER_BIT=4:
  - Byte 0x07 -> parity bit 1, then stop. tx_ready is low for 44 cycles.
  - Byte 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte handshake and serial line between a producer and uart_tx.
// The producer uses the master modport, the transmitter uses the slave modport.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       txd;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  txd
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output txd
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one byte per handshake, 8N1 frame LSB first, idle line high.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam logic [15:0] LP_TERM = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      r_state;
    logic        r_txd;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    logic        w_accept;
    logic        w_term;

    assign w_accept = bus.tx_valid && (r_state == S_IDLE);
    assign w_term   = (r_baud == LP_TERM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_txd    <= 1'b1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (r_state == S_IDLE) begin
            r_txd  <= 1'b1;
            r_baud <= '0;
            if (w_accept) begin
                r_shift  <= bus.tx_data;
                r_state  <= S_START;
                r_txd    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_parity <= 1'b0;
`endif
            end
        end else if (!w_term) begin
            r_baud <= r_baud + 16'd1;
        end else begin
            r_baud <= '0;
            case (r_state)
                S_START: begin
                    r_state <= S_DATA;
                    r_txd   <= r_shift[0];
                    r_bit   <= '0;
                end
                S_DATA: begin
`ifdef UART_TX_PARITY_EN
                    // Parity accumulates from the captured copy as each bit leaves.
                    r_parity <= r_parity ^ r_shift[0];
`endif
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_txd   <= r_parity ^ r_shift[0];
`else
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
`endif
                    end else begin
                        r_shift <= r_shift >> 1;
                        r_txd   <= r_shift[1];
                        r_bit   <= r_bit + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    r_state <= S_STOP;
                    r_txd   <= 1'b1;
                end
`endif
                S_STOP: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_ready = (r_state == S_IDLE);
    assign bus.tx_busy  = (r_state != S_IDLE);
    assign bus.txd      = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4; frame bits checked on every cycle.
// Builds for both the 8N1 default and UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    uart_tx_if u_if ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " txd"},   {7'd0, u_if.txd},      8'd1);
        chk({tag, " ready"}, {7'd0, u_if.tx_ready}, 8'd1);
        chk({tag, " busy"},  {7'd0, u_if.tx_busy},  8'd0);
    endtask

    // Entered #1 after the accept edge; walks the whole frame one cycle at a time.
    task automatic frame_expect(input logic [7:0] b, input int pulse_at,
                                input logic [7:0] pdata, input int abort_at);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        for (int c = 0; c < NB * CPB; c++) begin
            if (c == abort_at) begin
                reset = 1'b1;
                tick;
                chk_idle($sformatf("abort b=%0h", b));
                reset = 1'b0;
                tick;
                chk_idle($sformatf("post-abort b=%0h", b));
                return;
            end
            if (pulse_at >= 0 && c == pulse_at) begin
                u_if.tx_valid = 1'b1;
                u_if.tx_data  = pdata;
            end else if (pulse_at >= 0 && c == pulse_at + 1) begin
                u_if.tx_valid = 1'b0;
            end
            chk($sformatf("txd b=%0h c=%0d", b, c),   {7'd0, u_if.txd},      {7'd0, bits[c / CPB]});
            chk($sformatf("ready b=%0h c=%0d", b, c), {7'd0, u_if.tx_ready}, 8'd0);
            chk($sformatf("busy b=%0h c=%0d", b, c),  {7'd0, u_if.tx_busy},  8'd1);
            tick;
        end
        chk_idle($sformatf("end b=%0h", b));
    endtask

    task automatic accept(input logic [7:0] b);
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = b;
        tick;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset held two cycles with a byte offered: nothing may be accepted.
        reset         = 1'b1;
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = 8'h99;
        tick;
        chk_idle("reset1");
        tick;
        chk_idle("reset2");
        reset         = 1'b0;
        u_if.tx_valid = 1'b0;
        tick;
        chk_idle("after reset");

        // Single byte 0x55.
        accept(8'h55);
        u_if.tx_valid = 1'b0;
        frame_expect(8'h55, -1, 8'h00, -1);

        // Back-to-back: valid stays high, data changes mid-frame.
        accept(8'hA5);
        u_if.tx_data = 8'h3C;
        frame_expect(8'hA5, -1, 8'h00, -1);
        tick;
        u_if.tx_valid = 1'b0;
        frame_expect(8'h3C, -1, 8'h00, -1);

        // Pulse during data bit 2 of 0x00 is ignored.
        accept(8'h00);
        u_if.tx_valid = 1'b0;
        frame_expect(8'h00, 3 * CPB + 1, 8'hFF, -1);
        for (int i = 0; i < 12; i++) begin
            chk_idle($sformatf("no second frame %0d", i));
            tick;
        end

        // Reset during data bit 3 of 0x81, then a clean 0x42.
        accept(8'h81);
        u_if.tx_valid = 1'b0;
        frame_expect(8'h81, -1, 8'h00, 4 * CPB + 1);
        accept(8'h42);
        u_if.tx_valid = 1'b0;
        frame_expect(8'h42, -1, 8'h00, -1);

`ifdef UART_TX_PARITY_EN
        accept(8'h07);
        u_if.tx_valid = 1'b0;
        frame_expect(8'h07, -1, 8'h00, -1);
        accept(8'h03);
        u_if.tx_valid = 1'b0;
        frame_expect(8'h03, -1, 8'h00, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
